operand_fetch: RTL and testbench

Register-read and decode stage directly upstream of the 3-bit-command ALU in the MIPS-subset datapath. Accepts one 32-bit instruction per handshake, decodes it to an ALU command, reads operands from an internal 32x32 register file (or builds an immediate), and presents the result in a one-entry output register with a valid/ready handshake. Writeback writes into the register file through a separate write port.

---
 rtl/alu_pkg.sv | 63 ++++++
 rtl/regfile.sv | 32 +++
 rtl/operand_fetch.sv | 92 +++++++++
 tb/tb_operand_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the MIPS-subset front end: ALU commands, opcodes, functs,
// register index type, and the instruction decode helper used by operand_fetch.
package alu_pkg;

    typedef logic [4:0] reg_idx_t;

    // 3'b101 (NAND) exists in the ALU but is never produced by this decoder
    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_SUB = 3'b001;
    localparam logic [2:0] CMD_XOR = 3'b010;
    localparam logic [2:0] CMD_SLT = 3'b011;
    localparam logic [2:0] CMD_AND = 3'b100;
    localparam logic [2:0] CMD_NOR = 3'b110;
    localparam logic [2:0] CMD_OR  = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef struct packed {
        logic [2:0] cmd;
        logic       use_imm;
        logic       sext;
        logic       ill;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d = '{cmd: CMD_ADD, use_imm: 1'b0, sext: 1'b0, ill: 1'b0};
        case (instr[31:26])
            OP_RTYPE:
                case (instr[5:0])
                    FN_ADD:  d.cmd = CMD_ADD;
                    FN_SUB:  d.cmd = CMD_SUB;
                    FN_XOR:  d.cmd = CMD_XOR;
                    FN_SLT:  d.cmd = CMD_SLT;
                    FN_AND:  d.cmd = CMD_AND;
                    FN_NOR:  d.cmd = CMD_NOR;
                    FN_OR:   d.cmd = CMD_OR;
                    default: d.ill = 1'b1;
                endcase
            OP_ADDI: d = '{cmd: CMD_ADD, use_imm: 1'b1, sext: 1'b1, ill: 1'b0};
            OP_SLTI: d = '{cmd: CMD_SLT, use_imm: 1'b1, sext: 1'b1, ill: 1'b0};
            OP_ANDI: d = '{cmd: CMD_AND, use_imm: 1'b1, sext: 1'b0, ill: 1'b0};
            OP_ORI:  d = '{cmd: CMD_OR,  use_imm: 1'b1, sext: 1'b0, ill: 1'b0};
            OP_XORI: d = '{cmd: CMD_XOR, use_imm: 1'b1, sext: 1'b0, ill: 1'b0};
            default: d.ill = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile.sv
// 32-entry register file: two combinational read ports, one synchronous write
// port, async active-high clear; entry 0 reads as zero and ignores writes.
module regfile
    import alu_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  reg_idx_t         ra_addr,
    output logic [width-1:0] ra_data,
    input  reg_idx_t         rb_addr,
    output logic [width-1:0] rb_data,
    input  logic             wr_en,
    input  reg_idx_t         wr_addr,
    input  logic [width-1:0] wr_data
);

    logic [width-1:0] mem [32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/operand_fetch.sv
// Decode + register-read stage feeding the 3-bit-command ALU, one-entry output
// register with valid/ready. Define OPERAND_FWD_EN for same-cycle write-through bypass.
module operand_fetch
    import alu_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [width-1:0] wr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] operandA,
    output logic [width-1:0] operandB,
    output logic [2:0]       command,
    output logic [4:0]       dest,
    output logic             illegal
);

    reg_idx_t         rs, rt, rd, nxt_dest;
    dec_t             dec;
    logic [width-1:0] rs_val, rt_val, rs_op, rt_op, imm, nxt_a, nxt_b;
    logic             fire;

    assign rs = instr[25:21];
    assign rt = instr[20:16];
    assign rd = instr[15:11];

    regfile #(.width(width)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (rs),
        .ra_data (rs_val),
        .rb_addr (rt),
        .rb_data (rt_val),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

`ifdef OPERAND_FWD_EN
    // a write landing on the capture edge is visible to the captured operands
    assign rs_op = (wr_en && wr_addr != '0 && wr_addr == rs) ? wr_data : rs_val;
    assign rt_op = (wr_en && wr_addr != '0 && wr_addr == rt) ? wr_data : rt_val;
`else
    assign rs_op = rs_val;
    assign rt_op = rt_val;
`endif

    assign in_ready = !out_valid || out_ready;
    assign fire     = in_valid && in_ready;

    always_comb begin
        dec      = decode(instr);
        imm      = dec.sext ? {{(width-16){instr[15]}}, instr[15:0]}
                            : {{(width-16){1'b0}}, instr[15:0]};
        nxt_a    = rs_op;
        nxt_b    = dec.use_imm ? imm : rt_op;
        nxt_dest = dec.use_imm ? rt : rd;
        if (dec.ill) begin
            nxt_a    = '0;
            nxt_b    = '0;
            nxt_dest = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            operandA  <= '0;
            operandB  <= '0;
            command   <= '0;
            dest      <= '0;
            illegal   <= 1'b0;
        end else if (fire) begin
            out_valid <= 1'b1;
            operandA  <= nxt_a;
            operandB  <= nxt_b;
            command   <= dec.cmd;
            dest      <= nxt_dest;
            illegal   <= dec.ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: driver pushes model-predicted bundles on
// accept, a negedge monitor compares every presented bundle and pops on transfer.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid, in_ready, wr_en, out_valid, out_ready, illegal;
    logic [31:0] instr, wr_data, operandA, operandB;
    logic [4:0]  wr_addr, dest;
    logic [2:0]  command;

    operand_fetch #(.width(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .operandA  (operandA),
        .operandB  (operandB),
        .command   (command),
        .dest      (dest),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  cmd;
        logic [4:0]  dest;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mregs[32];
    int          compared = 0;
    int          mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // register value seen by an instruction captured this cycle
    function automatic logic [31:0] src(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef OPERAND_FWD_EN
        if (wr_en && wr_addr == r) return wr_data;
`endif
        return mregs[r];
    endfunction

    function automatic exp_t model(input logic [31:0] i);
        exp_t e;
        logic [31:0] simm, zimm;
        simm = {{16{i[15]}}, i[15:0]};
        zimm = {16'd0, i[15:0]};
        e = '{a: src(i[25:21]), b: src(i[20:16]), cmd: 3'd0, dest: i[15:11], ill: 1'b0};
        if (i[31:26] == 6'd0) begin
            case (i[5:0])
                6'h20: e.cmd = 3'd0;
                6'h22: e.cmd = 3'd1;
                6'h26: e.cmd = 3'd2;
                6'h2A: e.cmd = 3'd3;
                6'h24: e.cmd = 3'd4;
                6'h27: e.cmd = 3'd6;
                6'h25: e.cmd = 3'd7;
                default: e.ill = 1'b1;
            endcase
        end else begin
            e.dest = i[20:16];
            case (i[31:26])
                6'h08: begin e.b = simm; e.cmd = 3'd0; end
                6'h0A: begin e.b = simm; e.cmd = 3'd3; end
                6'h0C: begin e.b = zimm; e.cmd = 3'd4; end
                6'h0D: begin e.b = zimm; e.cmd = 3'd7; end
                6'h0E: begin e.b = zimm; e.cmd = 3'd2; end
                default: e.ill = 1'b1;
            endcase
        end
        if (e.ill) e = '{a: 32'd0, b: 32'd0, cmd: 3'd0, dest: 5'd0, ill: 1'b1};
        return e;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] i;
        i = $urandom;
        if ($urandom_range(7) != 0) begin
            case ($urandom_range(5))
                0: i[31:26] = 6'h00;
                1: i[31:26] = 6'h08;
                2: i[31:26] = 6'h0A;
                3: i[31:26] = 6'h0C;
                4: i[31:26] = 6'h0D;
                default: i[31:26] = 6'h0E;
            endcase
            if (i[31:26] == 6'h00 && $urandom_range(7) != 0) begin
                case ($urandom_range(6))
                    0: i[5:0] = 6'h20;
                    1: i[5:0] = 6'h22;
                    2: i[5:0] = 6'h26;
                    3: i[5:0] = 6'h2A;
                    4: i[5:0] = 6'h24;
                    5: i[5:0] = 6'h27;
                    default: i[5:0] = 6'h25;
                endcase
            end
        end
        return i;
    endfunction

    // monitor: whatever is presented must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
            if (out_valid && q.size() != 0) begin
                chk("operandA", operandA, q[0].a);
                chk("operandB", operandB, q[0].b);
                chk("command", {29'd0, command}, {29'd0, q[0].cmd});
                chk("dest", {27'd0, dest}, {27'd0, q[0].dest});
                chk("illegal", {31'd0, illegal}, {31'd0, q[0].ill});
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic cyc(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(posedge clk);
        #1;
        in_valid = iv; instr = ins; out_ready = ordy;
        wr_en = we; wr_addr = wa; wr_data = wd;
        @(negedge clk);
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() == 0});
        if (iv && q.size() == 0) q.push_back(model(ins));
        if (we && wa != 5'd0) mregs[wa] = wd;
    endtask

    task automatic rst_seq();
        in_valid = 1'b0; wr_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst operandA", operandA, 32'd0);
        chk("rst operandB", operandB, 32'd0);
        chk("rst cmd/dest/ill", {23'd0, command, dest, illegal}, 32'd0);
        q.delete();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        in_valid = 1'b0; instr = '0; out_ready = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #1;
        rst_seq();
        cyc(0, 32'h0, 1, 1, 5'd1, 32'd5);
        cyc(0, 32'h0, 1, 1, 5'd2, 32'd3);
        cyc(1, 32'h00221820, 1, 0, 5'd0, 32'd0);      // add $3,$1,$2
        cyc(1, 32'h2024FFFF, 1, 0, 5'd0, 32'd0);      // addi $4,$1,-1
        cyc(1, 32'h3424FFFF, 1, 0, 5'd0, 32'd0);      // ori $4,$1,0xFFFF
        cyc(0, 32'h0, 1, 1, 5'd0, 32'd7);             // write to R0 ignored
        cyc(1, 32'h00002825, 1, 0, 5'd0, 32'd0);      // or $5,$0,$0
        cyc(1, 32'h00221818, 1, 0, 5'd0, 32'd0);      // funct 0x18 illegal
        // stall with R[1] rewritten underneath the held bundle
        cyc(1, 32'h00221820, 0, 0, 5'd0, 32'd0);
        for (int k = 0; k < 5; k++) cyc(1, 32'h00223022, 0, 1, 5'd1, 32'd100 + k);
        cyc(1, 32'h00223022, 1, 0, 5'd0, 32'd0);
        cyc(1, 32'h00223022, 1, 1, 5'd1, 32'd9);      // sub $6,$1,$2 with same-cycle write
        cyc(0, 32'h0, 1, 0, 5'd0, 32'd0);
        // reset in the middle of a stall
        cyc(1, 32'h00221820, 0, 0, 5'd0, 32'd0);
        cyc(0, 32'h0, 0, 0, 5'd0, 32'd0);
        #1;
        rst_seq();
        cyc(1, 32'h00221820, 1, 0, 5'd0, 32'd0);
        cyc(1, 32'h3424FFFF, 1, 0, 5'd0, 32'd0);
        for (int k = 0; k < 400; k++)
            cyc($urandom_range(3) != 0, rnd_instr(), $urandom_range(2) != 0,
                $urandom_range(1) != 0, 5'($urandom), $urandom);
        cyc(0, 32'h0, 1, 0, 5'd0, 32'd0);
        cyc(0, 32'h0, 1, 0, 5'd0, 32'd0);
        chk("drain", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
